// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the default carry-in used for plain addition.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CIN_ADD = 1'b0;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle for serial_add_ctrl. Defining SERIAL_ADD_SUB_EN adds
// the 'sub' request bit that selects a-b instead of a+b.
//
// Handshake: 'start' is a request sampled only while the controller is idle;
// a/b (and sub) are captured on that accepting edge. 'busy' is high while bits
// are being processed, 'done' is a one-cycle valid pulse for sum/cout, which
// then hold until the next accepted start. There is no backpressure.
interface serial_add_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_bit.sv
// Combinational full-adder cell made of two XOR/AND half-add stages; the
// controller feeds it one operand bit pair per clock.
module serial_add_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic h1_s, h1_c, h2_c;

    assign h1_s = a ^ b;
    assign h1_c = a & b;
    assign s    = h1_s ^ ci;
    assign h2_c = h1_s & ci;
    assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first, one bit per clock through a single
// full-adder cell. Optional SERIAL_ADD_SUB_EN adds a subtract mode (a + ~b + 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_add_if.slave   bus,
    output state_t        state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] load_b;
    logic             load_ci;
    logic             bit_s;
    logic             bit_co;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    assign load_b  = bus.sub ? ~bus.b : bus.b;
    assign load_ci = bus.sub;
`else
    assign load_b  = bus.b;
    assign load_ci = CIN_ADD;
`endif

    serial_add_bit u_bit (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= load_b;
                        carry  <= load_ci;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // New bit enters at the MSB so the LSB-first result lands aligned.
                    sum_q <= {bit_s, sum_q[WIDTH-1:1]};
                    carry <= bit_co;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    if (cnt == LAST) begin
                        cout_q <= bit_co;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): randomized and directed operands
// against an arithmetic reference, with a decoupled result scoreboard.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic   clk;
    logic   rst_n;
    logic   sub_sel;
    state_t state;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = sub_sel;
`endif

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W:0]     exp_q[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    int             cyc      = 0;
    int             acc_cyc  = 0;
    logic           active   = 1'b0;
    logic [W-1:0]   held_sum = '0;
    logic           held_cout = 1'b0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Plain arithmetic reference: {cout, sum}.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        int unsigned xa;
        int unsigned yb;
        logic [W:0]  r;
        xa = x;
        yb = y;
        if (s) begin
            r[W-1:0] = W'(xa - yb);
            r[W]     = (xa >= yb);
        end else begin
            r = (W+1)'(xa + yb);
        end
        return r;
    endfunction

    // Request model: a start is taken when no operation is in flight,
    // and an operation occupies WIDTH+2 cycles from its accept edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 1'b0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            if (bus.start && (!active || (cyc - acc_cyc) >= W + 2)) begin
                active  = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(ref_result(bus.a, bus.b, sub_sel));
            end
        end
    end

    // Monitor: busy/done timing every cycle, result popped on done, hold afterwards.
    int         d;
    logic       busy_exp;
    logic       done_exp;
    logic [W:0] r;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_sum  = '0;
            held_cout = 1'b0;
        end
        d        = cyc - acc_cyc;
        busy_exp = active && d >= 0 && d < W;
        done_exp = active && d == W;
        check("busy", {8'h00, bus.busy}, {8'h00, busy_exp});
        check("done", {8'h00, bus.done}, {8'h00, done_exp});
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                r         = exp_q.pop_front();
                held_sum  = r[W-1:0];
                held_cout = r[W];
            end
        end
        if (!busy_exp) begin
            check("sum", {1'b0, bus.sum}, {1'b0, held_sum});
            check("cout", {8'h00, bus.cout}, {8'h00, held_cout});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        sub_sel   = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic settle();
        repeat (W + 2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        sub_sel   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0); settle();
        repeat (3) @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0); settle();
        issue(8'h00, 8'h00, 1'b0); settle();

        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
`else
            issue(W'($urandom), W'($urandom), 1'b0);
`endif
            settle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        sub_sel = 1'b0;

        // start held high with operands changing every cycle
        for (int i = 0; i < 4 * (W + 2) + 3; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        settle();

        // asynchronous reset in the middle of a run
        issue(8'hC3, 8'h7E, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {8'h00, bus.busy}, 0);
        check("rst_done", {8'h00, bus.done}, 0);
        check("rst_sum", {1'b0, bus.sum}, 0);
        check("rst_cout", {8'h00, bus.cout}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(8'h01, 8'h02, 1'b0); settle();

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h20, 8'h10, 1'b1); settle();
        issue(8'h10, 8'h20, 1'b1); settle();
        issue(8'h37, 8'h37, 1'b1); settle();
        sub_sel = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
